// File: rtl/disp_sched.sv
// Display source scheduler: round-robin over valid sources, with one-shot alerts pre-empting the rotation.
// Outputs are registered; an alert request in cycle k is acknowledged and shown on the edge ending cycle k+1.
module disp_sched #(
   parameter int HOLD_T  = 20,
   parameter int ALERT_T = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce100ms,
   input  logic        en,
   input  logic [63:0] src,
   input  logic [3:0]  valid,
   input  logic [3:0]  alert_req,
   output logic [3:0]  alert_ack,
   output logic [15:0] dat,
   output logic [1:0]  sel,
   output logic        alert_active
);

   typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_T - 1);
   localparam logic [7:0] ALERT_LAST = 8'(ALERT_T - 1);

   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [1:0]  asel_q, asel_d;
   logic [3:0]  pending_q, pending_d;
   logic [3:0]  ack_q, ack_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic [15:0] dat_q, dat_d;
   logic [3:0]  grant;
   logic [1:0]  pick, first, nxt;
   logic        take;

   function automatic logic [1:0] lowest(input logic [3:0] v);
      lowest = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (v[i]) lowest = 2'(i);
   endfunction

   assign pick  = lowest(pending_q);
   assign first = lowest(valid);

   // Nearest valid index after sel_q, wrapping; falls back to sel_q when no other source is valid.
   always_comb begin
      nxt = sel_q;
      for (int k = 3; k >= 1; k--)
         if (valid[sel_q + 2'(k)]) nxt = sel_q + 2'(k);
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      asel_d  = asel_q;
      tcnt_d  = tcnt_q;
      ack_d   = 4'b0000;
      grant   = 4'b0000;
      take    = 1'b0;
      if (!en) begin
         state_d = IDLE;
         tcnt_d  = 8'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|pending_q) begin
                  take = 1'b1;
               end else if (|valid) begin
                  state_d = SHOW;
                  sel_d   = first;
                  tcnt_d  = 8'd0;
               end
            end
            SHOW: begin
               if (|pending_q) begin
                  take = 1'b1;
               end else if (valid == 4'b0000) begin
                  state_d = IDLE;
                  tcnt_d  = 8'd0;
               end else if (!valid[sel_q]) begin
                  sel_d  = nxt;
                  tcnt_d = 8'd0;
               end else if (ce100ms) begin
                  if (tcnt_q == HOLD_LAST) begin
                     sel_d  = nxt;
                     tcnt_d = 8'd0;
                  end else begin
                     tcnt_d = tcnt_q + 8'd1;
                  end
               end
            end
            ALERT: begin
               if (ce100ms) begin
                  if (tcnt_q == ALERT_LAST) begin
                     tcnt_d = 8'd0;
                     if (|pending_q) begin
                        take = 1'b1;
                     end else if (valid[sel_q]) begin
                        state_d = SHOW;
                     end else if (|valid) begin
                        state_d = SHOW;
                        sel_d   = nxt;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     tcnt_d = tcnt_q + 8'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         // The saved rotation index is left alone so the rotation resumes where it was interrupted.
         if (take) begin
            state_d     = ALERT;
            asel_d      = pick;
            tcnt_d      = 8'd0;
            grant[pick] = 1'b1;
            ack_d[pick] = 1'b1;
         end
      end
      pending_d = (pending_q & ~grant) | alert_req;
      unique case (state_d)
         SHOW:    dat_d = src[{sel_d, 4'h0} +: 16];
         ALERT:   dat_d = src[{asel_d, 4'h0} +: 16];
         default: dat_d = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= 2'd0;
         asel_q    <= 2'd0;
         pending_q <= 4'b0000;
         tcnt_q    <= 8'd0;
         dat_q     <= 16'h0000;
         ack_q     <= 4'b0000;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         asel_q    <= asel_d;
         pending_q <= pending_d;
         tcnt_q    <= tcnt_d;
         dat_q     <= dat_d;
         ack_q     <= ack_d;
      end
   end

   assign dat          = dat_q;
   assign sel          = sel_q;
   assign alert_ack    = ack_q;
   assign alert_active = (state_q == ALERT);

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched; alert grants are tracked in a scoreboard of expected (index, data) pairs.
module tb_disp_sched;

   logic        clk = 1'b0;
   logic        rst, ce100ms, en;
   logic [63:0] src;
   logic [3:0]  valid, alert_req, alert_ack;
   logic [15:0] dat;
   logic [1:0]  sel;
   logic        alert_active;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0]  idx;
      logic [15:0] val;
   } exp_t;
   exp_t sb[$];
   exp_t e_mon;

   logic [1:0]  rot_sel [6] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0};
   logic [15:0] rot_dat [6] = '{16'h0000, 16'h1111, 16'h1111, 16'h3333, 16'h3333, 16'h0000};

   disp_sched #(.HOLD_T(2), .ALERT_T(3)) dut (
      .clk(clk), .rst(rst), .ce100ms(ce100ms), .en(en), .src(src), .valid(valid),
      .alert_req(alert_req), .alert_ack(alert_ack), .dat(dat), .sel(sel),
      .alert_active(alert_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ce_edge();
      ce100ms = 1'b1;
      step(1);
      ce100ms = 1'b0;
   endtask

   task automatic ce_tick();
      ce_edge();
      step(2);
   endtask

   // Every acknowledge must match the oldest outstanding expected grant.
   always @(posedge clk) begin
      #1;
      if (!rst && alert_ack !== 4'b0000) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_unexpected: ack %b dat %h with nothing expected", alert_ack, dat);
         end else begin
            e_mon = sb.pop_front();
            assert (alert_ack === (4'b0001 << e_mon.idx) && dat === e_mon.val) else begin
               fails++;
               $error("FAIL sb_grant: ack %b dat %h expected ack %b dat %h",
                      alert_ack, dat, 4'b0001 << e_mon.idx, e_mon.val);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; ce100ms = 1'b0; valid = 4'b0000; alert_req = 4'b0000;
      src = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      #2;
      chk("rst_dat", dat, 0);
      chk("rst_sel", sel, 0);
      chk("rst_ack", alert_ack, 0);
      chk("rst_active", alert_active, 0);
      step(1);
      rst = 1'b0;
      step(1);
      chk("idle_dat", dat, 0);

      // Rotation over valid = 1011
      en = 1'b1; valid = 4'b1011;
      step(1);
      chk("show_sel0", sel, 0);
      chk("show_active", alert_active, 0);
      for (int i = 0; i < 6; i++) begin
         ce_tick();
         chk($sformatf("rot_sel%0d", i), sel, 32'(rot_sel[i]));
         chk($sformatf("rot_dat%0d", i), dat, 32'(rot_dat[i]));
      end

      // Alert pre-emption from sel=1
      ce_tick(); ce_tick();
      chk("pre_sel1", sel, 1);
      ce_tick();
      alert_req = 4'b0100; sb.push_back('{2'd2, 16'h2222});
      step(1);
      alert_req = 4'b0000;
      chk("pend_no_ack", alert_ack, 0);
      step(1);
      chk("alert_ack", alert_ack, 4'b0100);
      chk("alert_dat", dat, 16'h2222);
      chk("alert_on", alert_active, 1);
      chk("alert_sel_kept", sel, 1);
      step(1);
      chk("ack_oneshot", alert_ack, 0);
      ce_tick(); ce_tick();
      chk("alert_hold", alert_active, 1);
      ce_tick();
      chk("alert_exp_active", alert_active, 0);
      chk("alert_exp_sel", sel, 1);
      chk("alert_exp_dat", dat, 16'h1111);
      ce_tick();
      chk("resume_tcnt0", sel, 1);
      ce_tick();
      chk("resume_adv", sel, 3);

      // Two simultaneous requests, then a repeat request in the grant cycle
      alert_req = 4'b1010; sb.push_back('{2'd1, 16'h1111}); sb.push_back('{2'd3, 16'h3333});
      step(1);
      alert_req = 4'b0000;
      step(1);
      chk("multi_ack1", alert_ack, 4'b0010);
      chk("multi_dat1", dat, 16'h1111);
      ce_tick(); ce_tick();
      ce100ms = 1'b1; alert_req = 4'b1000; sb.push_back('{2'd3, 16'h3333});
      step(1);
      ce100ms = 1'b0; alert_req = 4'b0000;
      chk("multi_ack3", alert_ack, 4'b1000);
      chk("multi_dat3", dat, 16'h3333);
      chk("multi_b2b", alert_active, 1);
      ce_tick(); ce_tick(); ce_edge();
      chk("multi_ack3_again", alert_ack, 4'b1000);
      chk("multi_again_active", alert_active, 1);
      ce_tick(); ce_tick(); ce_edge();
      chk("multi_done_active", alert_active, 0);
      chk("multi_done_sel", sel, 3);
      chk("multi_done_dat", dat, 16'h3333);

      // Valid drop while showing sel=1
      ce_tick(); ce_tick(); ce_tick(); ce_tick();
      chk("drop_pre_sel", sel, 1);
      src[15:0] = 16'hAAAA;
      ce_tick();
      valid = 4'b1001;
      step(1);
      chk("drop_sel", sel, 3);
      chk("drop_dat", dat, 16'h3333);
      ce_tick();
      chk("drop_tcnt0", sel, 3);
      ce_tick();
      chk("drop_wrap_sel", sel, 0);
      chk("drop_wrap_dat", dat, 16'hAAAA);
      valid = 4'b0000;
      step(1);
      chk("none_dat", dat, 0);
      chk("none_active", alert_active, 0);

      // Enable removed during an alert
      valid = 4'b1010;
      step(1);
      chk("en_show_sel", sel, 1);
      chk("en_show_dat", dat, 16'h1111);
      alert_req = 4'b0100; sb.push_back('{2'd2, 16'h2222});
      step(1);
      alert_req = 4'b0000;
      step(1);
      chk("en_alert_on", alert_active, 1);
      en = 1'b0;
      step(1);
      chk("en_off_active", alert_active, 0);
      chk("en_off_dat", dat, 0);
      chk("en_off_ack", alert_ack, 0);
      alert_req = 4'b0010; sb.push_back('{2'd1, 16'h1111});
      step(1);
      alert_req = 4'b0000;
      step(3);
      chk("en_off_held", alert_active, 0);
      chk("en_off_noack", alert_ack, 0);
      en = 1'b1;
      step(1);
      chk("en_on_ack", alert_ack, 4'b0010);
      chk("en_on_dat", dat, 16'h1111);
      chk("en_on_active", alert_active, 1);
      chk("en_on_sel", sel, 1);

      // Asynchronous reset between clock edges
      #2;
      rst = 1'b1;
      #1;
      chk("arst_dat", dat, 0);
      chk("arst_sel", sel, 0);
      chk("arst_ack", alert_ack, 0);
      chk("arst_active", alert_active, 0);
      step(1);
      rst = 1'b0; valid = 4'b0000;
      step(5);
      chk("arst_pend_lost", alert_active, 0);
      chk("arst_pend_noack", alert_ack, 0);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
